// File: rtl/fft_reorder_256.sv
// Bit-reversed to natural-order reorder buffer for a streaming FFT.
// Ping-pong banks: one frame is written while the previous one is read out.
module fft_reorder_256 #(
  parameter int N  = 256,
  parameter int AW = $clog2(N),
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic                 sop_in,
  input  logic signed [DW-1:0] x_re,
  input  logic signed [DW-1:0] x_im,
  output logic                 valid_out,
  output logic                 sop_out,
  output logic                 eop_out,
  output logic signed [DW-1:0] y_re,
  output logic signed [DW-1:0] y_im,
  output logic                 err
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t          state, state_nxt;
  logic [2*DW-1:0] mem0 [N];
  logic [2*DW-1:0] mem1 [N];
  logic [AW-1:0]   wr_cnt, wr_idx, wr_addr, rd_cnt;
  logic            wr_bank, rd_bank, frame_open;
  logic [1:0]      full, full_set, full_clr;
  logic            acc_sop, acc_cont, accept, wr_last;
  logic            rd_en, rd_last;
  logic [2*DW-1:0] rd_data_p1;
  logic            vld_p1, sop_p1, eop_p1;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  // Write side: a sop always restarts the frame at index 0
  always_comb begin
    acc_sop  = valid_in & sop_in;
    acc_cont = valid_in & ~sop_in & frame_open;
    accept   = acc_sop | acc_cont;
    wr_idx   = acc_sop ? '0 : wr_cnt;
    wr_addr  = bitrev(wr_idx);
    wr_last  = accept && (wr_idx == LAST);
  end

  always_ff @(posedge clk) begin
    if (accept && !wr_bank) mem0[wr_addr] <= {x_re, x_im};
  end

  always_ff @(posedge clk) begin
    if (accept && wr_bank) mem1[wr_addr] <= {x_re, x_im};
  end

  // Reader: IDLE issues address 0 in the same cycle it sees a full bank
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_last   = 1'b0;
    full_set  = '0;
    full_clr  = '0;
    full_set[wr_bank] = wr_last;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          rd_en     = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (rd_cnt == LAST) begin
          rd_last           = 1'b1;
          full_clr[rd_bank] = 1'b1;
          state_nxt         = full[~rd_bank] ? READ : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      frame_open <= 1'b0;
      full       <= '0;
      vld_p1     <= 1'b0;
      sop_p1     <= 1'b0;
      eop_p1     <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= valid_in & (sop_in ? frame_open : ~frame_open);
      if (accept) begin
        if (wr_last) begin
          wr_cnt     <= '0;
          frame_open <= 1'b0;
          wr_bank    <= ~wr_bank;
        end else begin
          wr_cnt     <= wr_idx + 1'b1;
          frame_open <= 1'b1;
        end
      end
      full <= (full & ~full_clr) | full_set;
      if (rd_en) begin
        rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
        if (rd_last) rd_bank <= ~rd_bank;
      end
      vld_p1 <= rd_en;
      sop_p1 <= rd_en && (rd_cnt == '0);
      eop_p1 <= rd_last;
    end
  end

  // Stage p1: registered memory read
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_p1 <= rd_bank ? mem1[rd_cnt] : mem0[rd_cnt];
  end

  // Stage p2: output registers, data held while idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
      y_re      <= '0;
      y_im      <= '0;
    end else begin
      valid_out <= vld_p1;
      sop_out   <= sop_p1;
      eop_out   <= eop_p1;
      if (vld_p1) begin
        y_re <= $signed(rd_data_p1[2*DW-1:DW]);
        y_im <= $signed(rd_data_p1[DW-1:0]);
      end
    end
  end

endmodule

// File: doc/fft_reorder_256.md
FFT_REORDER_256 -- requirements
Module: fft_reorder_256

Interface
REQ-001 Parameter N, default 256, frame length in samples; power of two; log2(N) = AW (default 8).
REQ-002 Parameter DW, default 16, sample component width in bits.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 valid_in  input  1  input sample strobe from FFT core valid_out.
REQ-006 sop_in  input  1  marks sample 0 of an input frame; qualified by valid_in.
REQ-007 x_re  input  DW  signed real part, bit-reversed frame order.
REQ-008 x_im  input  DW  signed imaginary part, bit-reversed frame order.
REQ-009 valid_out  output  1  output sample strobe, natural order.
REQ-010 sop_out  output  1  high with natural-order sample 0.
REQ-011 eop_out  output  1  high with natural-order sample N-1.
REQ-012 y_re  output  DW  signed real part, registered.
REQ-013 y_im  output  DW  signed imaginary part, registered.
REQ-014 err  output  1  one-cycle pulse on input protocol violation.

Function
REQ-015 Block SHALL hold two N-entry banks (ping-pong), each entry 2*DW bits, single write port and single read port per bank.
REQ-016 Write counter wr_cnt (AW bits) SHALL count accepted samples; sample wr_cnt SHALL be written to address bitrev(wr_cnt) of write bank.
REQ-017 Sample accepted = valid_in high at rising edge while frame open, or valid_in & sop_in high (opens frame, wr_cnt taken as 0).
REQ-018 valid_in may drop for any number of cycles mid-frame; wr_cnt SHALL hold during gaps.
REQ-019 On acceptance of sample N-1: write bank SHALL be marked full, write bank select SHALL toggle, frame SHALL close, wr_cnt SHALL wrap to 0.
REQ-020 Reader states: IDLE, READ; IDLE -> READ when any bank full; READ -> IDLE after address N-1 issued and other bank not full; READ -> READ (other bank, rd_cnt=0) if other bank full at that cycle.
REQ-021 In READ, reader SHALL issue one natural-order address per cycle, no gaps, 0..N-1; bank full flag SHALL clear on cycle address N-1 is issued.
REQ-022 Latency: last input sample accepted at edge k -> read address 0 issued at edge k+1 -> valid_out, sop_out, y at edge k+2 (output registers after 1-cycle memory read).
REQ-023 Back-to-back frames at one sample per cycle SHALL stream out with no valid_out gap; no overflow is reachable at input rate <= 1 sample/cycle.
REQ-024 sop_in with valid_in while frame open SHALL discard partial frame, restart at wr_cnt=0 with that sample, pulse err.
REQ-025 valid_in without sop_in while no frame open SHALL drop the sample and pulse err.
REQ-026 Simultaneous bank-full set (write side) and bank-full clear (read side) on different banks SHALL both take effect same cycle.
REQ-027 y_re/y_im SHALL be bit-exact copies of stored samples; no arithmetic, no scaling.
REQ-028 When valid_out low, y_re/y_im SHALL hold last value; sop_out, eop_out SHALL be low.

Reset
REQ-029 rst_n low at rising edge SHALL clear wr_cnt, rd_cnt, both full flags, bank selects (write bank 0, read bank 0), frame-open flag, reader to IDLE.
REQ-030 Outputs after reset edge: valid_out=0, sop_out=0, eop_out=0, err=0, y_re=0, y_im=0; memory contents need not be cleared.
REQ-031 Reset mid-frame or mid-readout SHALL discard all buffered data; no further valid_out until a new complete frame.

Verification
REQ-032 Ramp: x_re=x_im=i, i=0..N-1 contiguous, sop at i=0 -> valid_out 256 contiguous cycles from k+2; output n has y_re=bitrev8(n) (n=0:0, n=1:128, n=2:64, n=255:255); sop_out at n=0, eop_out at n=255.
REQ-033 Gapped input: same ramp with valid_in every other cycle -> identical output sequence, contiguous 256-cycle burst starting 2 cycles after last accepted sample.
REQ-034 Two back-to-back frames (second ramp offset +1000) -> 512 contiguous valid_out cycles, sop_out at cycles 0 and 256, second frame n=1 gives y_re=1128.
REQ-035 sop_in reasserted at sample 100 -> err pulse one cycle; output appears only after 256 samples from new sop, containing only new-frame data.
REQ-036 valid_in=1, sop_in=0 while idle, 5 samples -> err pulses each, no valid_out.
REQ-037 rst_n low for one cycle at output sample 50 -> valid_out=0 from next edge, no remaining samples emitted; following full frame processed normally.
